// File: rtl/alu_ser_pkg.sv
// Shared definitions for the ALU result serializer: FSM state encoding
// and the byte order used when a result is split into two bytes.
package alu_ser_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] SEND_LO = 2'b01;
    localparam logic [1:0] SEND_HI = 2'b10;

    // 1: the least significant byte of a result goes out first.
    localparam bit LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = IDLE,
        S_SEND_LO = SEND_LO,
        S_SEND_HI = SEND_HI
    } state_t;

endpackage

// File: rtl/alu_result_serializer_if.sv
// Interface bundle between the ALU output, the serializer and the
// UART TX byte stream.
interface alu_result_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 2 * DATA_WIDTH
);
    logic [RES_WIDTH-1:0]  res_in;
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  full;
    logic                  overflow;

    // Environment side: supplies results and transmitter readiness.
    modport master (
        output res_in, res_valid, tx_ready,
        input  tx_data, tx_valid, full, overflow
    );

    // Serializer side.
    modport slave (
        input  res_in, res_valid, tx_ready,
        output tx_data, tx_valid, full, overflow
    );
endinterface

// File: rtl/alu_result_serializer_result_fifo.sv
// Circular result buffer with push/pop, full/empty and an occupancy
// count. The head entry is readable combinationally so the serializer can
// load its output register on the same edge that pops the entry.
module result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_reg;
    logic [AW-1:0]    rptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come from the pre-edge count, so a push at full is
    // refused even when a pop happens on the same edge.
    assign full     = (count_reg == FULL_COUNT);
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rptr_reg];

    // Storage array: written only, never reset (count defines validity).
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since
    // DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and sends each one as two bytes over a valid/ready
// byte stream, flagging results dropped because the buffer was full.
module alu_result_serializer
    import alu_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 2 * DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_result_serializer_if.slave  bus
);
    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   tx_data_reg;
    logic                    tx_valid_reg;
    logic [DATA_WIDTH-1:0]   hold_hi_reg;
    logic                    overflow_reg;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [RES_WIDTH-1:0]    head;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [DATA_WIDTH-1:0]   first_byte;
    logic [DATA_WIDTH-1:0]   second_byte;

    result_fifo #(
        .WIDTH (RES_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.res_valid),
        .push_data (bus.res_in),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign first_byte  = LSB_FIRST ? head[DATA_WIDTH-1:0] : head[RES_WIDTH-1:DATA_WIDTH];
    assign second_byte = LSB_FIRST ? head[RES_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];

    // Pop whenever the FSM is about to load a new result: from idle, or
    // right as the high byte is accepted so results stream without a gap.
    assign fifo_pop = !fifo_empty &&
                      ((state_reg == S_IDLE) || ((state_reg == S_SEND_HI) && bus.tx_ready));

    // Output FSM: registered byte and valid, held stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            hold_hi_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    tx_valid_reg <= 1'b0;
                    if (!fifo_empty) begin
                        tx_data_reg  <= first_byte;
                        hold_hi_reg  <= second_byte;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= S_SEND_LO;
                    end
                end
                S_SEND_LO: begin
                    if (bus.tx_ready) begin
                        tx_data_reg <= hold_hi_reg;
                        state_reg   <= S_SEND_HI;
                    end
                end
                S_SEND_HI: begin
                    if (bus.tx_ready) begin
                        if (!fifo_empty) begin
                            tx_data_reg  <= first_byte;
                            hold_hi_reg  <= second_byte;
                            tx_valid_reg <= 1'b1;
                            state_reg    <= S_SEND_LO;
                        end else begin
                            tx_valid_reg <= 1'b0;
                            state_reg    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid_reg <= 1'b0;
                    state_reg    <= S_IDLE;
                end
            endcase
        end
    end

    // One-cycle pulse for every result refused because the buffer was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= bus.res_valid && fifo_full;
        end
    end

    assign bus.tx_data  = tx_data_reg;
    assign bus.tx_valid = tx_valid_reg;
    assign bus.full     = fifo_full;
    assign bus.overflow = overflow_reg;
endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Downstream stage of the ALU: it captures each registered ALU result (ALU_OUT/OUT_VALID) into a small result buffer. It then emits each result as two bytes, low byte first, over a valid/ready byte stream toward the UART TX path. It decouples the one-result-per-cycle ALU output from the slower byte-serial transmitter and flags results lost to overflow.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one output byte.
- RES_WIDTH, 16, ALU result width. Fixed at 2*DATA_WIDTH.
- DEPTH, 4, number of result entries buffered. Power of two, at least 2.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- RES_IN  in  RES_WIDTH  ALU result, connected to ALU_OUT.
- RES_VALID  in  1  result qualifier, connected to OUT_VALID. One result per cycle while high.
- TX_DATA  out  DATA_WIDTH  byte to the transmitter, registered.
- TX_VALID  out  1  TX_DATA holds a valid byte, registered.
- TX_READY  in  1  transmitter accepts TX_DATA on this edge when TX_VALID is also high.
- FULL  out  1  buffer holds DEPTH entries, combinational from count.
- OVERFLOW  out  1  one-cycle registered pulse: a result arrived while FULL and was dropped.

## Operation
- Buffer: circular, with write pointer, read pointer and count. Width of count is log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Write: on an edge where RES_VALID=1 and FULL=0, RES_IN is stored at wptr and wptr increments.
- Drop: if RES_VALID=1 and FULL=0 is false because FULL=1, nothing is stored and OVERFLOW is 1 on the next cycle.
- FULL is evaluated on the pre-edge count. A write is rejected at count==DEPTH even if a pop happens on the same edge.
- Simultaneous write and pop leave count unchanged and advance both pointers.
- FSM states:
  - IDLE: TX_VALID=0. If count!=0: pop the head entry, load the high byte into hold_hi, drive TX_DATA=low byte, set TX_VALID=1, go to SEND_LO.
  - SEND_LO: hold TX_DATA and TX_VALID while TX_READY=0. On TX_READY=1: TX_DATA=hold_hi, go to SEND_HI.
  - SEND_HI: hold while TX_READY=0. On TX_READY=1:
    - if count!=0, pop the next entry and drive its low byte (TX_VALID stays 1), go to SEND_LO;
    - otherwise TX_VALID=0, go to IDLE.
- "count" in the FSM checks means the pre-edge count. A result written on the same edge is not visible until the next cycle.
- TX_DATA and TX_VALID must not change while TX_VALID=1 and TX_READY=0.
- Illegal state encoding: return to IDLE with TX_VALID=0.

## Timing
- Reset values: TX_DATA=0, TX_VALID=0, OVERFLOW=0, FULL=0. Internally: count=0, wptr=rptr=0, hold_hi=0, state=IDLE.
- Reset asserted mid-transfer discards any buffered entries and any partially sent result. No byte is emitted after reset until a new result is written.
- Latency from an empty, idle buffer, with RES_VALID=1 in cycle n:
  - entry stored at edge n, so count=1 in cycle n+1;
  - low byte popped at edge n+1, so TX_VALID=1 with the low byte in cycle n+2;
  - with TX_READY held at 1, the high byte is on TX_DATA in cycle n+3.
- Throughput: one byte per cycle with TX_READY=1. Consecutive results stream without an IDLE gap.
- OVERFLOW pulses exactly one cycle per dropped result. Consecutive drops give consecutive pulses.
- FULL reflects count in the same cycle. It rises in the cycle after the write that makes count reach DEPTH.

## Structure
- Shared package alu_ser_pkg holds:
  - state encoding localparams: IDLE=2'b00, SEND_LO=2'b01, SEND_HI=2'b10;
  - byte-order constant LSB_FIRST=1.
- Sub-module result_fifo: synchronous circular buffer with push, pop, full and empty, parameterized by width and depth.
- The top level holds the FSM, hold_hi, and the OVERFLOW register.

## Test plan
- Single result 16'hA55A at cycle n, TX_READY=1 -> TX_DATA=8'h5A in cycle n+2, TX_DATA=8'hA5 in cycle n+3, TX_VALID=0 in cycle n+4, OVERFLOW never 1.
- Backpressure: result 16'h1234 with TX_READY=0 for 5 cycles -> TX_DATA=8'h34 and TX_VALID=1 held stable for all 5 cycles. With TX_READY=1 afterwards -> 8'h12, then idle.
- Fill and drop, DEPTH=4, TX_READY=0: results 0x0001 through 0x0005 on consecutive cycles ->
  - first result popped into the output stage and the next 4 buffered, so FULL=1 and nothing is dropped;
  - a 6th result 0x0006 -> OVERFLOW pulses for one cycle.
  - Drain with TX_READY=1 -> bytes 01,00,02,00,03,00,04,00,05,00 on consecutive cycles, with no 06.
- Back-to-back: results 16'hBEEF and 16'hCAFE on consecutive cycles, TX_READY=1 -> EF,BE,FE,CA on 4 consecutive cycles, TX_VALID continuously 1.
- Simultaneous push and pop: with count=1 in SEND_HI, apply TX_READY=1 and RES_VALID=1 on the same edge -> count stays 1 and byte order is preserved.
- Reset mid-operation: assert RST in SEND_HI with 2 entries buffered -> all outputs 0 immediately. After release with no new input, TX_VALID stays 0 for 10 cycles.
